sum_demux2: RTL
===============

# sum_demux2

Two-way demultiplexer for the 256-bit signed sum datapath. It accepts one stream of sums on a valid/ready handshake and routes each word, by a per-word select bit, to one of two downstream consumers. Each output channel has its own 2-entry buffer. Backpressure on one channel never stalls traffic bound for the other. It sits upstream of the consumers that previously fed the sum_0/sum_1 selection point, so results can be split back out per destination.

## Interface
Parameters:
- WIDTH, 256, data word width (signed, passed through unmodified)
- CNT_W, 16, width of per-channel delivered-word counters

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input word present
- in_ready  out  1  input accepted this cycle when high together with in_valid
- in_sel  in  1  destination: 0 -> channel 0, 1 -> channel 1
- in_data  in  WIDTH  signed input sum
- out0_valid / out1_valid  out  1  channel has a word
- out0_ready / out1_ready  in  1  consumer accepts
- out0_data / out1_data  out  WIDTH  head word of channel buffer
- cnt0 / cnt1  out  CNT_W  words delivered on channel, saturating
- busy  out  1  either channel buffer non-empty

## Operation
- Input transfer occurs when in_valid && in_ready. The word is written to the buffer of channel in_sel.
- in_ready = !full[in_sel]. It depends combinationally on in_sel and registered occupancy only. A same-cycle pop does not create space (no bypass).
- Per channel: 2-entry FIFO with occupancy states EMPTY(0), ONE(1), FULL(2). Transitions:
  - push only: +1
  - pop only: -1
  - push+pop in ONE: stays ONE, order preserved
  - push+pop in FULL: impossible, because in_ready is low
  - pop in EMPTY: impossible, because valid is low
- outN_valid = occupancy != 0. outN_data = oldest entry, held stable while outN_valid && !outN_ready.
- Output transfer on outN_valid && outN_ready increments cntN. The counter saturates at all-ones and never wraps.
- in_sel and in_data are ignored when in_valid is low. A word is never duplicated or dropped.
- busy = out0_valid || out1_valid.
- Reset, asserted at any time including mid-transfer:
  - buffers emptied, stored data cleared to 0
  - outN_valid = 0, outN_data = 0, cntN = 0, busy = 0
  - in_ready = 1 while in reset and after release
  - any in-flight word is discarded

## Timing
- Latency: a word accepted in cycle N appears on outN_valid/outN_data in cycle N+1.
- Throughput: one word per cycle per channel sustained when the consumer holds ready high.
- Counter update is visible the cycle after the output handshake.
- Channels are independent. A full channel 0 blocks only words with in_sel=0.

## Structure
- Shared package sum_pkg:
  - SUM_WIDTH = 256
  - CNT_W default
  - typedef sum_t (signed [SUM_WIDTH-1:0])
  - FIFO_DEPTH = 2
- Sub-module sum_fifo2: 2-entry synchronous FIFO with push/pop, full/empty, head data, async active-low reset. Instantiated once per channel.
- Top level holds the routing, the in_ready selection, the counters and busy.

## Test plan
- Reset mid-stream: push 0x..AA to ch0, assert rst_n=0 next cycle -> out0_valid=0, cnt0=0, in_ready=1; no 0x..AA delivered after release.
- Routing: in_sel=0, data=0x..0001; in_sel=1, data=-1 (all F) -> out0 gets 0x..0001 at N+1, out1 gets all-F at N+2, sign preserved, cnt0=cnt1=1.
- Backpressure isolation: out0_ready=0, three pushes to ch0 -> third sees in_ready=0 and is held. A push to ch1 in the same stall is accepted and delivered.
- Ordering/streaming: push A,B,C to ch1 back-to-back with out1_ready=1 -> delivered A,B,C in consecutive cycles, cnt1=3.
- Simultaneous push/pop at ONE: ch0 holds A, push B while popping A -> occupancy stays 1, out0_data=B next cycle.
- Saturation (CNT_W=4): 20 deliveries on ch0 -> cnt0 stays 15, cnt1=0.

Source files
------------

// File: rtl/sum_pkg.sv
// Shared definitions for the sum datapath.
// Holds the datapath width, the default counter width, the per-channel buffer
// depth, the signed sum type and the occupancy encoding of the 2-entry buffers.
package sum_pkg;

  localparam int SUM_WIDTH     = 256;
  localparam int DEFAULT_CNT_W = 16;
  localparam int FIFO_DEPTH    = 2;

  typedef logic signed [SUM_WIDTH-1:0] sum_t;

  // Occupancy of a 2-entry channel buffer.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/sum_demux2_if.sv
// Handshake bundle of sum_demux2.
// One valid/ready input stream with a destination select bit, and two
// valid/ready output streams.
//   master : the side that drives the input stream and consumes both outputs
//   slave  : the demultiplexer itself
interface sum_demux2_if #(
  parameter int WIDTH = sum_pkg::SUM_WIDTH
);

  logic                    in_valid;
  logic                    in_ready;
  logic                    in_sel;
  logic signed [WIDTH-1:0] in_data;

  logic                    out0_valid;
  logic                    out0_ready;
  logic signed [WIDTH-1:0] out0_data;

  logic                    out1_valid;
  logic                    out1_ready;
  logic signed [WIDTH-1:0] out1_data;

  modport master (
    output in_valid, in_sel, in_data, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data
  );

  modport slave (
    input  in_valid, in_sel, in_data, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data
  );

endinterface

// File: rtl/sum_fifo2.sv
// Two-entry synchronous FIFO used as one output channel buffer.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (empties and zeroes)
//   push, din   : write request and data (ignored when full)
//   pop         : read request (ignored when empty)
//   dout        : oldest stored entry, zero when empty
//   full, empty : occupancy flags from registered state
module sum_fifo2
  import sum_pkg::*;
#(
  parameter int WIDTH = SUM_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic signed [WIDTH-1:0] din,
  output logic signed [WIDTH-1:0] dout,
  output logic                    full,
  output logic                    empty
);

  occ_e                    occ;
  occ_e                    occ_next;
  logic signed [WIDTH-1:0] mem [FIFO_DEPTH];
  logic                    do_push;
  logic                    do_pop;

  // Guard requests so a stray push into a full buffer or pop from an empty
  // one can never corrupt the stored order.
  assign do_push = push && (occ != OCC_FULL);
  assign do_pop  = pop  && (occ != OCC_EMPTY);

  // Occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ <= OCC_EMPTY;
    end else begin
      occ <= occ_next;
    end
  end

  // Occupancy transitions; a simultaneous push and pop leaves the count as is.
  always_comb begin
    occ_next = occ;
    case (occ)
      OCC_EMPTY: if (do_push) occ_next = OCC_ONE;
      OCC_ONE: begin
        if (do_push && !do_pop)      occ_next = OCC_FULL;
        else if (do_pop && !do_push) occ_next = OCC_EMPTY;
      end
      OCC_FULL:  if (do_pop) occ_next = OCC_ONE;
      default:   occ_next = OCC_EMPTY;
    endcase
  end

  // Status flags decoded from the registered occupancy only.
  always_comb begin
    full  = (occ == OCC_FULL);
    empty = (occ == OCC_EMPTY);
  end

  // Storage is a shift register with mem[0] as head. A pop shifts the
  // second entry forward (or takes the incoming word when pushing in ONE),
  // which keeps the head always at a fixed location for the output mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_pop) begin
      mem[0] <= (do_push && occ == OCC_ONE) ? din : mem[1];
      mem[1] <= '0;
    end else if (do_push) begin
      if (occ == OCC_EMPTY) begin
        mem[0] <= din;
      end else begin
        mem[1] <= din;
      end
    end
  end

  assign dout = mem[0];

endmodule

// File: rtl/sum_demux2.sv
// Two-way demultiplexer for the signed sum datapath.
// Routes each accepted input word to channel in_sel, each channel buffering
// up to two words so a stalled consumer never blocks the other channel.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : input stream plus two output streams (slave side)
//   cnt0, cnt1 : saturating counts of words delivered per channel
//   busy       : high while either channel holds a word
module sum_demux2
  import sum_pkg::*;
#(
  parameter int WIDTH = SUM_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  sum_demux2_if.slave      bus,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic             busy
);

  logic full0, full1;
  logic empty0, empty1;
  logic accept;
  logic push0, push1;
  logic pop0, pop1;

  // Ready follows only the selected channel's registered fullness; a pop in
  // the same cycle does not open a slot, keeping ready off the consumer path.
  assign bus.in_ready = bus.in_sel ? !full1 : !full0;
  assign accept       = bus.in_valid && bus.in_ready;
  assign push0        = accept && !bus.in_sel;
  assign push1        = accept &&  bus.in_sel;

  assign bus.out0_valid = !empty0;
  assign bus.out1_valid = !empty1;
  assign pop0           = bus.out0_valid && bus.out0_ready;
  assign pop1           = bus.out1_valid && bus.out1_ready;

  sum_fifo2 #(.WIDTH(WIDTH)) u_fifo0 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push0),
    .pop   (pop0),
    .din   (bus.in_data),
    .dout  (bus.out0_data),
    .full  (full0),
    .empty (empty0)
  );

  sum_fifo2 #(.WIDTH(WIDTH)) u_fifo1 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push1),
    .pop   (pop1),
    .din   (bus.in_data),
    .dout  (bus.out1_data),
    .full  (full1),
    .empty (empty1)
  );

  // Delivered-word counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (pop0 && cnt0 != {CNT_W{1'b1}}) cnt0 <= cnt0 + CNT_W'(1);
      if (pop1 && cnt1 != {CNT_W{1'b1}}) cnt1 <= cnt1 + CNT_W'(1);
    end
  end

  assign busy = bus.out0_valid || bus.out1_valid;

endmodule
